// File: rtl/br_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : br_write_ctrl
// Brief   : Write-port sequencer for the 32-entry register bank: zero sweep
//           after reset, then core writeback merged with an aux requester.
// Revision: 1.0
// ============================================================================
module br_write_ctrl #(
    parameter int N        = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         core_we,
    input  logic [4:0]   core_rd,
    input  logic [N-1:0] core_wd,
    output logic         core_stall,
    output logic         busy,
    input  logic         aux_valid,
    output logic         aux_ready,
    input  logic [4:0]   aux_rd,
    input  logic [N-1:0] aux_wd,
    output logic         br_we,
    output logic [4:0]   br_a3,
    output logic [N-1:0] br_wd3
);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [3:0] c_max_wait = 4'(MAX_WAIT);

    state_t     r_state;
    logic [4:0] r_idx;
    logic [3:0] r_starve;

    logic w_core_stall;
    logic w_core_hit;
    logic w_aux_ready;
    logic w_aux_fire;

    always_comb begin
        w_core_stall = 1'b0;
        w_core_hit   = 1'b0;
        w_aux_ready  = 1'b0;
        w_aux_fire   = 1'b0;
        br_we        = 1'b0;
        br_a3        = 5'd0;
        br_wd3       = '0;
        busy         = 1'b1;
        if (!rst) begin
            if (r_state == ST_INIT) begin
                br_we = 1'b1;
                br_a3 = r_idx;
            end else begin
                busy         = 1'b0;
                w_core_stall = (r_starve == c_max_wait);
                // A core write to x0 never occupies the port, so aux may use it
                w_core_hit   = core_we && (core_rd != 5'd0) && !w_core_stall;
                w_aux_ready  = !w_core_hit;
                w_aux_fire   = aux_valid && w_aux_ready;
                if (w_core_hit) begin
                    br_we  = 1'b1;
                    br_a3  = core_rd;
                    br_wd3 = core_wd;
                end else if (w_aux_fire) begin
                    br_we  = (aux_rd != 5'd0);
                    br_a3  = aux_rd;
                    br_wd3 = aux_wd;
                end
            end
        end
    end

    assign core_stall = w_core_stall;
    assign aux_ready  = w_aux_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_INIT;
            r_idx    <= 5'd0;
            r_starve <= 4'd0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_idx <= r_idx + 5'd1;
                    if (r_idx == 5'd31) begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    if (!aux_valid || w_aux_fire) begin
                        r_starve <= 4'd0;
                    end else if (r_starve != c_max_wait) begin
                        r_starve <= r_starve + 4'd1;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_br_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_br_write_ctrl
// Brief   : Directed vector bench for br_write_ctrl with a register-bank model.
// Revision: 1.0
// ============================================================================
module tb_br_write_ctrl;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         core_we;
    logic [4:0]   core_rd;
    logic [N-1:0] core_wd;
    logic         core_stall;
    logic         busy;
    logic         aux_valid;
    logic         aux_ready;
    logic [4:0]   aux_rd;
    logic [N-1:0] aux_wd;
    logic         br_we;
    logic [4:0]   br_a3;
    logic [N-1:0] br_wd3;

    logic         preload = 1'b0;
    logic [N-1:0] bank [32];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    br_write_ctrl #(.N(N), .MAX_WAIT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .core_we    (core_we),
        .core_rd    (core_rd),
        .core_wd    (core_wd),
        .core_stall (core_stall),
        .busy       (busy),
        .aux_valid  (aux_valid),
        .aux_ready  (aux_ready),
        .aux_rd     (aux_rd),
        .aux_wd     (aux_wd),
        .br_we      (br_we),
        .br_a3      (br_a3),
        .br_wd3     (br_wd3)
    );

    // Register bank model driven by the controller's write port
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) bank[i] <= 32'hA500_0000 | i;
        end else if (br_we) begin
            bank[br_a3] <= br_wd3;
        end
    end

    typedef struct {
        logic         core_we;
        logic [4:0]   core_rd;
        logic [N-1:0] core_wd;
        logic         aux_valid;
        logic [4:0]   aux_rd;
        logic [N-1:0] aux_wd;
        logic         e_we;
        logic [4:0]   e_a3;
        logic [N-1:0] e_wd3;
        logic         e_ready;
        logic         e_stall;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic cwe, input logic [4:0] crd, input logic [N-1:0] cwd,
                         input logic av, input logic [4:0] ard, input logic [N-1:0] awd);
        core_we = cwe; core_rd = crd; core_wd = cwd;
        aux_valid = av; aux_rd = ard; aux_wd = awd;
    endtask

    task automatic check_out(input string tag, input logic we, input logic [4:0] a3,
                             input logic [N-1:0] wd, input logic rdy, input logic stl,
                             input logic bsy);
        chk({tag, ".br_we"}, 64'(br_we), 64'(we));
        chk({tag, ".br_a3"}, 64'(br_a3), 64'(a3));
        chk({tag, ".br_wd3"}, 64'(br_wd3), 64'(wd));
        chk({tag, ".aux_ready"}, 64'(aux_ready), 64'(rdy));
        chk({tag, ".core_stall"}, 64'(core_stall), 64'(stl));
        chk({tag, ".busy"}, 64'(busy), 64'(bsy));
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic check_sweep(input string tag);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            check_out($sformatf("%s[%0d]", tag, i), 1'b1, 5'(i), '0, 1'b0, 1'b0, 1'b1);
            next_cycle();
        end
    endtask

    initial begin
        //          cwe rd  cwd           av  ard  awd       we a3  wd3           rdy stl
        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 5'd6, 32'h66, 1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 5'd5,  32'h0,        1'b1, 5'd6, 32'h66, 1'b1, 5'd6,  32'h66,       1'b1, 1'b0};
        vecs[2] = '{1'b1, 5'd0,  32'hFFFF,     1'b1, 5'd7, 32'h12, 1'b1, 5'd7,  32'h12,       1'b1, 1'b0};
        vecs[3] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0, 32'h77, 1'b0, 5'd0,  32'h77,       1'b1, 1'b0};
        vecs[4] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0,  32'h0,        1'b1, 1'b0};
        vecs[5] = '{1'b1, 5'd10, 32'hAB,       1'b0, 5'd3, 32'h9,  1'b1, 5'd10, 32'hAB,       1'b0, 1'b0};
        vecs[6] = '{1'b1, 5'd0,  32'h5,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0,  32'h0,        1'b1, 1'b0};

        // Reset with both requesters active: outputs must stay forced
        rst = 1'b1;
        preload = 1'b1;
        drive(1'b1, 5'd4, 32'h1, 1'b1, 5'd8, 32'h2);
        @(negedge clk);
        check_out("rst0", 1'b0, 5'd0, '0, 1'b0, 1'b0, 1'b1);
        next_cycle();
        preload = 1'b0;
        @(negedge clk);
        check_out("rst1", 1'b0, 5'd0, '0, 1'b0, 1'b0, 1'b1);
        next_cycle();
        rst = 1'b0;

        check_sweep("sweep");

        drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
        @(negedge clk);
        check_out("run0", 1'b0, 5'd0, '0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 32; i++) chk($sformatf("bank_zero[%0d]", i), 64'(bank[i]), 64'd0);
        next_cycle();

        for (int v = 0; v < 7; v++) begin
            drive(vecs[v].core_we, vecs[v].core_rd, vecs[v].core_wd,
                  vecs[v].aux_valid, vecs[v].aux_rd, vecs[v].aux_wd);
            @(negedge clk);
            check_out($sformatf("vec%0d", v), vecs[v].e_we, vecs[v].e_a3, vecs[v].e_wd3,
                      vecs[v].e_ready, vecs[v].e_stall, 1'b0);
            next_cycle();
        end
        chk("x5", 64'(bank[5]), 64'hDEADBEEF);
        chk("x6", 64'(bank[6]), 64'h66);
        chk("x7", 64'(bank[7]), 64'h12);
        chk("x0", 64'(bank[0]), 64'h0);
        chk("x10", 64'(bank[10]), 64'hAB);

        // Starvation: aux blocked MAX_WAIT cycles, then forced through
        for (int c = 1; c <= 6; c++) begin
            drive(1'b1, 5'd3, 32'h3300 + c, (c <= 5), 5'd9, 32'h55);
            @(negedge clk);
            if (c == 5)
                check_out($sformatf("starve%0d", c), 1'b1, 5'd9, 32'h55, 1'b1, 1'b1, 1'b0);
            else
                check_out($sformatf("starve%0d", c), 1'b1, 5'd3, 32'h3300 + c, 1'b0, 1'b0, 1'b0);
            if (c == 6) begin
                chk("x9_starve", 64'(bank[9]), 64'h55);
                chk("x3_skipped", 64'(bank[3]), 64'h3304);
            end
            next_cycle();
        end

        // Withdrawal: dropping aux_valid clears the starvation count
        for (int k = 1; k <= 9; k++) begin
            drive(1'b1, 5'd4, 32'h4400 + k, (k != 4), 5'd11, 32'hBB);
            @(negedge clk);
            if (k == 9)
                check_out($sformatf("wd%0d", k), 1'b1, 5'd11, 32'hBB, 1'b1, 1'b1, 1'b0);
            else
                check_out($sformatf("wd%0d", k), 1'b1, 5'd4, 32'h4400 + k, 1'b0, 1'b0, 1'b0);
            next_cycle();
        end
        drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
        @(negedge clk);
        chk("x11_withdraw", 64'(bank[11]), 64'hBB);
        chk("x4_withdraw", 64'(bank[4]), 64'h4408);
        next_cycle();

        // Reset mid-sweep at idx 17, then a full restart
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            chk($sformatf("pre17_a3[%0d]", i), 64'(br_a3), 64'(i));
            next_cycle();
        end
        @(negedge clk);
        chk("at17_a3_before_rst", 64'(br_a3), 64'd17);
        rst = 1'b1;
        #1;
        check_out("mid_rst", 1'b0, 5'd0, '0, 1'b0, 1'b0, 1'b1);
        next_cycle();
        rst = 1'b0;
        check_sweep("resweep");
        @(negedge clk);
        chk("resweep_busy_low", 64'(busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/br_write_ctrl.md
# br_write_ctrl

Write-port controller for the 32-entry register bank. It owns the bank's single write port (`we`/`a3`/`wd3`) and sequences three sources onto it. After reset it runs a zero-initialisation sweep over all 32 entries. In normal operation it merges the core writeback path with an auxiliary requester (debug port or multicycle unit) behind a valid/ready handshake. Core writeback has priority; a starvation counter forces a one-cycle core stall so the auxiliary requester always makes progress.

## Interface
- `N`, 32, data width of the register bank
- `MAX_WAIT`, 4, consecutive blocked cycles allowed for the aux requester before a core stall is forced (range 1..15)
- `clk` in 1: single clock, all state updates on rising edge
- `rst` in 1: synchronous, active-high reset
- `core_we` in 1: core writeback request for this cycle
- `core_rd` in 5: core destination register
- `core_wd` in N: core writeback data
- `core_stall` out 1: core must hold its current instruction; `core_we` is ignored this cycle
- `busy` out 1: init sweep in progress; core must not advance
- `aux_valid` in 1: aux write request pending
- `aux_ready` out 1: aux write accepted this cycle when `aux_valid=1`
- `aux_rd` in 5: aux destination register
- `aux_wd` in N: aux data
- `br_we` out 1: to bank `we`
- `br_a3` out 5: to bank `a3`
- `br_wd3` out N: to bank `wd3`

## Operation
- States: INIT and RUN. Registered state: `state`, 5-bit `idx`, 4-bit `starve`.
- Reset (`rst=1` at an edge): `state=INIT`, `idx=0`, `starve=0`.
- While `rst=1`, outputs are forced: `br_we=0`, `busy=1`, `aux_ready=0`, `core_stall=0`.
- INIT:
  - Outputs: `br_we=1`, `br_a3=idx`, `br_wd3=0`, `busy=1`, `aux_ready=0`, `core_stall=0`.
  - `core_we` and `aux_valid` are ignored.
  - `idx` increments each cycle. At the edge where `idx=31`, go to RUN and clear `idx`.
  - Entry 0 is written too, so the bank's x0 storage is zeroed.
- RUN, `busy=0`:
  - `core_stall = (starve==MAX_WAIT)`.
  - `core_hit = core_we && core_rd!=0 && !core_stall`.
  - `aux_ready = !core_hit`. It is independent of `aux_valid`.
  - `aux_fire = aux_valid && aux_ready`.
  - If `core_hit`: `br_we=1`, `br_a3=core_rd`, `br_wd3=core_wd`.
  - Else if `aux_fire`: `br_we = (aux_rd!=0)`, `br_a3=aux_rd`, `br_wd3=aux_wd`.
  - Else: `br_we=0`, with `br_a3`/`br_wd3` equal to 0.
- x0 handling:
  - A core write to rd=0 does not use the port and does not block aux.
  - An aux write to rd=0 completes the handshake but produces no bank write.
- Starvation counter:
  - `starve` resets to 0 when `aux_fire=1` or `aux_valid=0`.
  - It increments, saturating at `MAX_WAIT`, when `aux_valid && !aux_ready`.
- Ordering: one bank write per cycle. When core and aux target the same rd, the write granted later holds the final value.
- Aux data must stay stable while `aux_valid=1 && aux_ready=0`; the controller does not buffer aux data.

## Timing
- Output paths are combinational from registered state plus the current-cycle inputs, so a core writeback lands at the same edge as in the unshared design (zero added latency).
- Sweep timing: the sweep occupies the first 32 cycles after `rst` falls, writing entries 0..31 in order. `busy` falls in cycle 32, the first RUN cycle.
- Starvation timing: with `aux_valid` held and the core writing nonzero rd every cycle, aux is blocked for exactly `MAX_WAIT` cycles. `core_stall=1` and the aux write both occur in cycle `MAX_WAIT+1`, and `starve` returns to 0 after that edge.
- Reset mid-sweep or mid-RUN takes effect at the next edge: state returns to INIT and the sweep restarts from idx 0. A blocked aux request is not completed; aux must re-present it after `busy` falls.
- `aux_valid` dropping before acceptance is allowed: no write occurs and `starve` clears.

## Test plan
- Reset sweep:
  - Stimulus: `rst=1` for 2 cycles, then release, with the bank's entries preloaded to nonzero values.
  - Required: `br_we=1` with `br_a3` = 0,1,…,31 over 32 cycles, `br_wd3=0`, `busy=1` throughout; `busy=0` in cycle 32; all 32 bank entries read 0.
- Core priority:
  - Stimulus: in RUN, `core_we=1`, `core_rd=5`, `core_wd=0xDEADBEEF`, with `aux_valid=1`, `aux_rd=6`.
  - Required: x5 = 0xDEADBEEF, `aux_ready=0`.
  - Next cycle, with `core_we=0`: `aux_ready=1` and x6 is written.
- x0 handling:
  - Stimulus: core writes rd=0 while aux requests rd=7, value 0x12.
  - Required: `aux_ready=1`, x7 = 0x12, x0 stays 0.
  - Stimulus: aux requests rd=0.
  - Required: handshake completes, `br_we=0`.
- Starvation (`MAX_WAIT=4`):
  - Stimulus: core writes x3 every cycle while `aux_valid=1`, `aux_rd=9`, `aux_wd=0x55`.
  - Required: `aux_ready=0` in cycles 1–4; in cycle 5 `core_stall=1`, `aux_ready=1`, x9 = 0x55, and the core's x3 write is not performed; cycle 6 has `core_stall=0`.
- Reset mid-sweep:
  - Stimulus: assert `rst` at idx=17 for 1 cycle.
  - Required: the sweep restarts at `br_a3=0` and `busy` stays high for a full 32 cycles after release.
- Aux withdrawal:
  - Stimulus: aux is blocked for 3 cycles, then `aux_valid=0` for 1 cycle, then re-asserted.
  - Required: `starve` resets, and a fresh 4 blocked cycles are needed before `core_stall` asserts.
